trace_access_scheduler: RTL and testbench

Shares one trace_repository between NUM_REQ consumers (Enokida instances). Each consumer can fetch the next unprocessed trace entry or retire an entry by data address. The block round-robin arbitrates, sequences the repository's fetch (trace_req) and retire (mark_done) handshakes one transaction at a time, and routes each response back to the granted consumer. A watchdog aborts any handshake the repository fails to answer.

---
 rtl/trace_access_scheduler.sv | 197 +++++++++++++++++++
 tb/tb_trace_access_scheduler.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/trace_access_scheduler.sv
// Round-robin front end that lets NUM_REQ consumers share one trace repository,
// running one fetch or retire handshake at a time with a watchdog on each wait.
module trace_access_scheduler #(
    parameter int NUM_REQ         = 2,
    parameter int DATA_ADDR_WIDTH = 16,
    parameter int TIMEOUT_CYCLES  = 255,
    parameter int TRACE_WIDTH     = 32
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic [NUM_REQ-1:0]                 fetch_req,
    output logic [NUM_REQ-1:0]                 rsp_valid,
    output logic [TRACE_WIDTH-1:0]             rsp_trace,
    output logic                               rsp_complete,
    input  logic [NUM_REQ-1:0]                 retire_req,
    input  logic [NUM_REQ*DATA_ADDR_WIDTH-1:0] retire_addr,
    output logic [NUM_REQ-1:0]                 retire_ack,
    output logic                               trace_req,
    input  logic [TRACE_WIDTH-1:0]             trace_out,
    input  logic                               entry_valid,
    input  logic                               processing_complete,
    output logic                               mark_done,
    output logic [DATA_ADDR_WIDTH-1:0]         addr_done,
    input  logic                               marked_valid,
    output logic                               timeout_err,
    output logic                               busy
);

    // state       | meaning
    // IDLE        | arbitrate: retire requests first, then fetch requests
    // FETCH_WAIT  | trace_req held, waiting for entry_valid / processing_complete
    // RETIRE_WAIT | mark_done held, waiting for marked_valid
    // RELEASE     | one quiet cycle so repository outputs settle before next grant
    typedef enum logic [1:0] {IDLE, FETCH_WAIT, RETIRE_WAIT, RELEASE} state_e;

    localparam int          IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [15:0] WD_LAST = 16'(TIMEOUT_CYCLES - 1);

    function automatic logic [IDX_W-1:0] rr_pick(input logic [NUM_REQ-1:0] req,
                                                 input logic [IDX_W-1:0]   ptr);
        logic found;
        int   idx;
        rr_pick = '0;
        found   = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(ptr) + k) % NUM_REQ;
            if (!found && req[idx]) begin
                rr_pick = IDX_W'(idx);
                found   = 1'b1;
            end
        end
    endfunction

    function automatic logic [IDX_W-1:0] rr_next(input logic [IDX_W-1:0] w);
        if (int'(w) == NUM_REQ - 1) rr_next = '0;
        else                        rr_next = w + 1'b1;
    endfunction

    function automatic logic [NUM_REQ-1:0] onehot(input logic [IDX_W-1:0] w);
        onehot = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (int'(w) == k) onehot[k] = 1'b1;
        end
    endfunction

    state_e                     state_q, state_d;
    logic [IDX_W-1:0]           win_q, win_d;
    logic [IDX_W-1:0]           fetch_ptr_q, fetch_ptr_d;
    logic [IDX_W-1:0]           retire_ptr_q, retire_ptr_d;
    logic [15:0]                wd_q, wd_d;
    logic                       trace_req_q, trace_req_d;
    logic                       mark_done_q, mark_done_d;
    logic [DATA_ADDR_WIDTH-1:0] addr_done_q, addr_done_d;
    logic [NUM_REQ-1:0]         rsp_valid_q, rsp_valid_d;
    logic                       rsp_complete_q, rsp_complete_d;
    logic [TRACE_WIDTH-1:0]     rsp_trace_q, rsp_trace_d;
    logic [NUM_REQ-1:0]         retire_ack_q, retire_ack_d;
    logic                       timeout_err_q, timeout_err_d;
    logic                       busy_q, busy_d;
    logic [IDX_W-1:0]           pick;

    always_comb begin
        state_d        = state_q;
        win_d          = win_q;
        fetch_ptr_d    = fetch_ptr_q;
        retire_ptr_d   = retire_ptr_q;
        wd_d           = wd_q;
        trace_req_d    = trace_req_q;
        mark_done_d    = mark_done_q;
        addr_done_d    = addr_done_q;
        rsp_valid_d    = '0;
        rsp_complete_d = 1'b0;
        rsp_trace_d    = rsp_trace_q;
        retire_ack_d   = '0;
        timeout_err_d  = timeout_err_q;
        pick           = '0;

        unique case (state_q)
            IDLE: begin
                if (|retire_req) begin
                    pick         = rr_pick(retire_req, retire_ptr_q);
                    win_d        = pick;
                    retire_ptr_d = rr_next(pick);
                    mark_done_d  = 1'b1;
                    addr_done_d  = retire_addr[int'(pick)*DATA_ADDR_WIDTH +: DATA_ADDR_WIDTH];
                    wd_d         = '0;
                    state_d      = RETIRE_WAIT;
                end else if (|fetch_req) begin
                    pick        = rr_pick(fetch_req, fetch_ptr_q);
                    win_d       = pick;
                    fetch_ptr_d = rr_next(pick);
                    trace_req_d = 1'b1;
                    wd_d        = '0;
                    state_d     = FETCH_WAIT;
                end
            end
            FETCH_WAIT: begin
                // an answer in the expiry cycle still counts as a normal answer
                if (entry_valid) begin
                    rsp_trace_d = trace_out;
                    rsp_valid_d = onehot(win_q);
                    trace_req_d = 1'b0;
                    state_d     = RELEASE;
                end else if (processing_complete || wd_q == WD_LAST) begin
                    rsp_valid_d    = onehot(win_q);
                    rsp_complete_d = 1'b1;
                    trace_req_d    = 1'b0;
                    state_d        = RELEASE;
                    if (!processing_complete) timeout_err_d = 1'b1;
                end else begin
                    wd_d = wd_q + 1'b1;
                end
            end
            RETIRE_WAIT: begin
                if (marked_valid || wd_q == WD_LAST) begin
                    retire_ack_d = onehot(win_q);
                    mark_done_d  = 1'b0;
                    state_d      = RELEASE;
                    if (!marked_valid) timeout_err_d = 1'b1;
                end else begin
                    wd_d = wd_q + 1'b1;
                end
            end
            RELEASE: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            win_q          <= '0;
            fetch_ptr_q    <= '0;
            retire_ptr_q   <= '0;
            wd_q           <= '0;
            trace_req_q    <= 1'b0;
            mark_done_q    <= 1'b0;
            addr_done_q    <= '0;
            rsp_valid_q    <= '0;
            rsp_complete_q <= 1'b0;
            rsp_trace_q    <= '0;
            retire_ack_q   <= '0;
            timeout_err_q  <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            win_q          <= win_d;
            fetch_ptr_q    <= fetch_ptr_d;
            retire_ptr_q   <= retire_ptr_d;
            wd_q           <= wd_d;
            trace_req_q    <= trace_req_d;
            mark_done_q    <= mark_done_d;
            addr_done_q    <= addr_done_d;
            rsp_valid_q    <= rsp_valid_d;
            rsp_complete_q <= rsp_complete_d;
            rsp_trace_q    <= rsp_trace_d;
            retire_ack_q   <= retire_ack_d;
            timeout_err_q  <= timeout_err_d;
            busy_q         <= busy_d;
        end
    end

    assign rsp_valid    = rsp_valid_q;
    assign rsp_trace    = rsp_trace_q;
    assign rsp_complete = rsp_complete_q;
    assign retire_ack   = retire_ack_q;
    assign trace_req    = trace_req_q;
    assign mark_done    = mark_done_q;
    assign addr_done    = addr_done_q;
    assign timeout_err  = timeout_err_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_trace_access_scheduler.sv
// Directed bench for trace_access_scheduler: fetch, fairness, retire priority,
// exhaustion, watchdog abort and asynchronous reset, with hand-computed expectations.
module tb_trace_access_scheduler;

    logic        clk;
    logic        rst_n;
    logic [1:0]  fetch_req;
    logic [1:0]  rsp_valid;
    logic [31:0] rsp_trace;
    logic        rsp_complete;
    logic [1:0]  retire_req;
    logic [31:0] retire_addr;
    logic [1:0]  retire_ack;
    logic        trace_req;
    logic [31:0] trace_out;
    logic        entry_valid;
    logic        processing_complete;
    logic        mark_done;
    logic [15:0] addr_done;
    logic        marked_valid;
    logic        timeout_err;
    logic        busy;

    int n_vec = 0;
    int n_err = 0;

    trace_access_scheduler #(
        .NUM_REQ(2), .DATA_ADDR_WIDTH(16), .TIMEOUT_CYCLES(4), .TRACE_WIDTH(32)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .fetch_req(fetch_req), .rsp_valid(rsp_valid), .rsp_trace(rsp_trace),
        .rsp_complete(rsp_complete), .retire_req(retire_req), .retire_addr(retire_addr),
        .retire_ack(retire_ack), .trace_req(trace_req), .trace_out(trace_out),
        .entry_valid(entry_valid), .processing_complete(processing_complete),
        .mark_done(mark_done), .addr_done(addr_done), .marked_valid(marked_valid),
        .timeout_err(timeout_err), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL global_time_limit: observed no finish, expected finish");
        $fatal(1, "time limit");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        fetch_req = '0; retire_req = '0; retire_addr = '0;
        trace_out = '0; entry_valid = 1'b0; processing_complete = 1'b0; marked_valid = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        logic got;

        apply_reset();
        chk("rst_busy", busy, 0);
        chk("rst_trace_req", trace_req, 0);
        chk("rst_mark_done", mark_done, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_trace", rsp_trace, 0);
        chk("rst_timeout_err", timeout_err, 0);

        // single fetch, answered in the 2nd wait cycle
        fetch_req = 2'b01;
        tick();
        chk("f1_trace_req_w1", trace_req, 1);
        chk("f1_busy_w1", busy, 1);
        tick();
        chk("f1_trace_req_w2", trace_req, 1);
        entry_valid = 1'b1; trace_out = 32'hCAFE_0001;
        tick();
        chk("f1_rsp_valid", rsp_valid, 2'b01);
        chk("f1_rsp_complete", rsp_complete, 0);
        chk("f1_rsp_trace", rsp_trace, 32'hCAFE_0001);
        chk("f1_trace_req_rel", trace_req, 0);
        chk("f1_busy_rel", busy, 1);
        fetch_req = 2'b00; entry_valid = 1'b0;
        tick();
        chk("f1_busy_idle", busy, 0);
        chk("f1_rsp_valid_pulse", rsp_valid, 0);

        // fairness with both consumers requesting continuously
        apply_reset();
        fetch_req = 2'b11;
        for (int t = 0; t < 4; t++) begin
            got = 1'b0;
            for (int c = 0; c < 12 && !got; c++) begin
                tick();
                if (rsp_valid != 2'b00) got = 1'b1;
                entry_valid = trace_req;
                trace_out   = 32'h1000 + t;
            end
            chk("fair_got_rsp", got, 1);
            chk("fair_grant", rsp_valid, (t % 2 == 0) ? 2'b01 : 2'b10);
            chk("fair_trace", rsp_trace, 32'h1000 + t);
            tick();
            entry_valid = 1'b0;
            chk("fair_pulse_1cyc", rsp_valid, 0);
        end
        fetch_req = 2'b00;
        tick(); tick();

        // retire beats a simultaneous fetch
        fetch_req = 2'b01; retire_req = 2'b10; retire_addr = {16'h00A4, 16'h1111};
        tick();
        chk("pr_mark_done", mark_done, 1);
        chk("pr_addr_done", addr_done, 16'h00A4);
        chk("pr_no_trace_req", trace_req, 0);
        marked_valid = 1'b1;
        tick();
        chk("pr_retire_ack", retire_ack, 2'b10);
        chk("pr_mark_done_rel", mark_done, 0);
        chk("pr_no_rsp", rsp_valid, 0);
        retire_req = 2'b00; marked_valid = 1'b0;
        tick();
        chk("pr_idle_busy", busy, 0);
        chk("pr_ack_pulse", retire_ack, 0);
        tick();
        chk("pr_fetch_trace_req", trace_req, 1);
        chk("pr_fetch_no_mark", mark_done, 0);

        // exhaustion answer
        processing_complete = 1'b1;
        tick();
        chk("ex_rsp_valid", rsp_valid, 2'b01);
        chk("ex_rsp_complete", rsp_complete, 1);
        fetch_req = 2'b00; processing_complete = 1'b0;
        tick();

        // entry_valid wins over processing_complete
        fetch_req = 2'b01;
        tick();
        chk("both_trace_req", trace_req, 1);
        entry_valid = 1'b1; processing_complete = 1'b1; trace_out = 32'hBEEF_0002;
        tick();
        chk("both_rsp_valid", rsp_valid, 2'b01);
        chk("both_rsp_complete", rsp_complete, 0);
        chk("both_rsp_trace", rsp_trace, 32'hBEEF_0002);
        chk("both_no_timeout", timeout_err, 0);
        fetch_req = 2'b00; entry_valid = 1'b0; processing_complete = 1'b0;
        tick();

        // silent repository: abort after 4 wait cycles
        fetch_req = 2'b10;
        for (int w = 0; w < 4; w++) begin
            tick();
            chk("to_wait_trace_req", trace_req, 1);
            chk("to_wait_no_rsp", rsp_valid, 0);
            chk("to_wait_no_err", timeout_err, 0);
        end
        tick();
        chk("to_rsp_valid", rsp_valid, 2'b10);
        chk("to_rsp_complete", rsp_complete, 1);
        chk("to_err_set", timeout_err, 1);
        chk("to_trace_req_drop", trace_req, 0);
        fetch_req = 2'b00;
        tick();

        // error stays sticky through a good transaction
        fetch_req = 2'b01;
        tick();
        entry_valid = 1'b1; trace_out = 32'h0000_7777;
        tick();
        chk("sticky_rsp_valid", rsp_valid, 2'b01);
        chk("sticky_rsp_complete", rsp_complete, 0);
        chk("sticky_err", timeout_err, 1);
        fetch_req = 2'b00; entry_valid = 1'b0;
        tick();

        // asynchronous reset between clock edges in FETCH_WAIT
        fetch_req = 2'b10;
        tick();
        chk("ar_trace_req_before", trace_req, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_trace_req", trace_req, 0);
        chk("ar_busy", busy, 0);
        chk("ar_rsp_valid", rsp_valid, 0);
        chk("ar_timeout_err", timeout_err, 0);
        tick();
        rst_n = 1'b1; fetch_req = 2'b11;

        // first grant after reset goes to consumer 0; answer lands in the expiry cycle
        for (int w = 0; w < 3; w++) begin
            tick();
            chk("exp_wait_trace_req", trace_req, 1);
        end
        tick();
        chk("exp_w4_no_rsp", rsp_valid, 0);
        entry_valid = 1'b1; trace_out = 32'h5A5A_0004;
        tick();
        chk("exp_rsp_valid", rsp_valid, 2'b01);
        chk("exp_rsp_complete", rsp_complete, 0);
        chk("exp_rsp_trace", rsp_trace, 32'h5A5A_0004);
        chk("exp_no_err", timeout_err, 0);
        fetch_req = 2'b00; entry_valid = 1'b0;
        tick();
        chk("exp_idle_busy", busy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
